dmem_req_ctrl: RTL and testbench
================================

// Module: dmem_req_ctrl
// PURPOSE
//  Data-side SRAM-like bus master between the EX-side pipeline register and the MEM stage.
//  - Formats loads and stores into byte strobes, size and lane-replicated wdata.
//  - Issues one request at a time (req/addr_ok/data_ok handshake) and returns the raw 32-bit load word to MEM.
//  - MEM does sign/zero byte extraction. This block only moves whole words.
//  - Holds the pipeline with stallreq while a request is outstanding. Buffers the response while the downstream stage is stalled.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width; only 32 is supported
// PORTS
//  clk            in   1       clock
//  resetn         in   1       asynchronous reset, active-low
//  flush          in   1       pipeline flush: exception or eret
//  stall_next     in   1       MEM stage stalled; response cannot be consumed
//  req_valid      in   1       memory op present this cycle
//  mem_op         in   8       one-hot {sb,sh,sw,lb,lbu,lh,lhu,lw}
//  vaddr          in   ADDR_W  effective address
//  store_data     in   32      rt value
//  addr_err_load  out  1       lh/lhu/lw misaligned; combinational, no request issued
//  addr_err_store out  1       sh/sw misaligned; combinational, no request issued
//  stallreq       out  1       freeze upstream stages
//  data_req       out  1       bus request
//  data_wr        out  1       1 = store
//  data_size      out  2       0 = byte, 1 = half, 2 = word
//  data_addr      out  ADDR_W  request address; low bits kept, not masked
//  data_wstrb     out  4       byte enables (stores); 0 for loads
//  data_wdata     out  32      lane-replicated store data
//  data_addr_ok   in   1       request accepted
//  data_data_ok   in   1       response / write done
//  data_rdata     in   32      load data, valid with data_data_ok
//  resp_valid     out  1       load word valid to MEM
//  resp_rdata     out  32      raw load word
// BEHAVIOUR
//  Reset (resetn = 0, async):
//  - State = IDLE; all outputs 0; request and buffer registers 0.
//  Formatting:
//  - sb: wstrb = 4'b0001 << a[1:0]; wdata = {4{sd[7:0]}}.
//  - sh: wstrb = a[1] ? 4'b1100 : 4'b0011; wdata = {2{sd[15:0]}}.
//  - sw: wstrb = 4'hF; wdata = sd.
//  - Loads: wstrb = 0.
//  Misalignment:
//  - Half-word ops require a[0] = 0. Word ops require a[1:0] = 0.
//  - On a misaligned op, raise the matching addr_err_* and do not accept the op.
//  Accept:
//  - In IDLE with req_valid & ~flush & aligned, latch the request fields and go to REQ.
//  - stallreq is high combinationally in the accept cycle.
//  FSM states: IDLE, REQ, WAIT, HOLD, CANCEL.
//  - REQ: data_req = 1 with stable fields until addr_ok.
//    - addr_ok & data_ok in the same cycle completes immediately.
//    - Otherwise addr_ok -> WAIT.
//  - WAIT: on data_ok:
//    - Load with ~stall_next: resp_valid = 1 for one cycle, then IDLE.
//    - Load with stall_next: buffer data_rdata, go to HOLD.
//    - Store: IDLE; resp_valid stays 0.
//  - HOLD: resp_valid = 1, resp_rdata = buffer. Go to IDLE in the first cycle stall_next = 0.
//  - stallreq = 1 in REQ and WAIT, and in the data_ok cycle. It is 0 in HOLD, where downstream stall governs.
//  Flush:
//  - IDLE: nothing accepted.
//  - REQ before addr_ok: data_req stays held until addr_ok (the bus cannot be retracted), then CANCEL.
//  - WAIT: go to CANCEL.
//  - REQ with addr_ok & data_ok in the flush cycle: discard the response, go to IDLE.
//  - HOLD: drop the buffer, go to IDLE.
//  - CANCEL: wait for data_ok, discard the data, resp_valid = 0, then IDLE.
//    - stallreq = req_valid: a new op waits for the drain.
//    - A flush arriving in CANCEL has no further effect.
//  Only one transaction is ever outstanding.
// STRUCTURE
//  - lib/defines.vh: mem_op one-hot bit indices, DSIZE_B/H/W constants, FSM state encodings.
//  - Sub-module dmem_store_fmt (combinational): mem_op + a[1:0] + sd -> size, wstrb, wdata, addr_err_*.
//  - Top level: FSM, request registers, response buffer.
// TESTING
//  1. sb at addr 0x..03, sd = 0x000000AB, addr_ok/data_ok 1 cycle later
//     -> size = 0, wstrb = 4'b1000, wdata = 0xABABABAB; stallreq high 3 cycles; no resp_valid.
//  2. lw at 0x1000, addr_ok delayed 2 cycles, data_ok = 0xDEADBEEF
//     -> data_req held stable 3 cycles; resp_valid one cycle with 0xDEADBEEF.
//  3. lh at 0x1002 with data_ok while stall_next = 1 for 4 cycles
//     -> HOLD: resp_valid = 1 with the buffered word through the stall; IDLE on release.
//  4. sh at 0x1001 -> addr_err_store = 1, data_req never rises, stallreq = 0.
//  5. flush in WAIT with a second lw presented next cycle
//     -> first data_ok discarded; second request issues only after it; stallreq high meanwhile.
//  6. resetn low mid-WAIT -> all outputs 0 immediately (async); IDLE after release.

Source files
------------

// File: rtl/dmem_req_ctrl_pkg.sv
//============================================================================
// dmem_req_ctrl_pkg : mem_op bit positions, bus size codes, FSM encodings
// Rev 1.0
//============================================================================
`default_nettype none

package dmem_req_ctrl_pkg;

  // mem_op is one-hot {sb,sh,sw,lb,lbu,lh,lhu,lw}, MSB first
  localparam int c_op_sb  = 7;
  localparam int c_op_sh  = 6;
  localparam int c_op_sw  = 5;
  localparam int c_op_lb  = 4;
  localparam int c_op_lbu = 3;
  localparam int c_op_lh  = 2;
  localparam int c_op_lhu = 1;
  localparam int c_op_lw  = 0;

  localparam logic [1:0] c_dsize_b = 2'd0;
  localparam logic [1:0] c_dsize_h = 2'd1;
  localparam logic [1:0] c_dsize_w = 2'd2;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_req    = 3'd1;
  localparam logic [2:0] c_st_wait   = 3'd2;
  localparam logic [2:0] c_st_hold   = 3'd3;
  localparam logic [2:0] c_st_cancel = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dmem_req_ctrl_store_fmt.sv
//============================================================================
// dmem_store_fmt : mem_op + addr[1:0] + store data -> size, strobes, wdata, errors
// Rev 1.0
//============================================================================
`default_nettype none

module dmem_store_fmt
  import dmem_req_ctrl_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic        is_store,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        addr_err_load,
  output logic        addr_err_store
);

  logic w_op_h;
  logic w_op_w;

  always_comb begin
    w_op_h   = mem_op[c_op_sh] | mem_op[c_op_lh] | mem_op[c_op_lhu];
    w_op_w   = mem_op[c_op_sw] | mem_op[c_op_lw];
    is_store = mem_op[c_op_sb] | mem_op[c_op_sh] | mem_op[c_op_sw];
    size     = w_op_w ? c_dsize_w : (w_op_h ? c_dsize_h : c_dsize_b);
    wstrb    = 4'b0000;
    wdata    = 32'h0;
    if (mem_op[c_op_sb]) begin
      wstrb = 4'b0001 << addr_lo;
      wdata = {4{store_data[7:0]}};
    end else if (mem_op[c_op_sh]) begin
      wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata = {2{store_data[15:0]}};
    end else if (mem_op[c_op_sw]) begin
      wstrb = 4'b1111;
      wdata = store_data;
    end
    addr_err_load  = ((mem_op[c_op_lh] | mem_op[c_op_lhu]) & addr_lo[0])
                   | (mem_op[c_op_lw] & (|addr_lo));
    addr_err_store = (mem_op[c_op_sh] & addr_lo[0]) | (mem_op[c_op_sw] & (|addr_lo));
  end

endmodule

`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
//============================================================================
// dmem_req_ctrl : single-outstanding data-side SRAM-like bus master
// Rev 1.0
//============================================================================
`default_nettype none

module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              stall_next,
  input  logic              req_valid,
  input  logic [7:0]        mem_op,
  input  logic [ADDR_W-1:0] vaddr,
  input  logic [DATA_W-1:0] store_data,
  output logic              addr_err_load,
  output logic              addr_err_store,
  output logic              stallreq,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata
);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_flushed;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_buf;

  logic              w_is_store;
  logic [1:0]        w_size;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic              w_err_ld;
  logic              w_err_st;
  logic              w_accept;
  logic              w_kill;
  logic              w_done;
  logic              w_ld_done;

  dmem_store_fmt u_fmt (
    .mem_op         (mem_op),
    .addr_lo        (vaddr[1:0]),
    .store_data     (store_data),
    .is_store       (w_is_store),
    .size           (w_size),
    .wstrb          (w_wstrb),
    .wdata          (w_wdata),
    .addr_err_load  (w_err_ld),
    .addr_err_store (w_err_st)
  );

  assign addr_err_load  = req_valid & w_err_ld;
  assign addr_err_store = req_valid & w_err_st;
  assign w_accept = (r_state == c_st_idle) & req_valid & ~flush & (|mem_op) & ~w_err_ld & ~w_err_st;
  // A flush seen while the request is still on the bus kills it once accepted
  assign w_kill    = r_flushed | flush;
  assign w_done    = ((r_state == c_st_req) & data_addr_ok & data_data_ok & ~w_kill)
                   | ((r_state == c_st_wait) & data_data_ok & ~flush);
  assign w_ld_done = w_done & ~r_wr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= c_st_idle;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:   if (w_accept) w_next = c_st_req;
      c_st_req: begin
        if (data_addr_ok && data_data_ok)
          w_next = (w_ld_done && stall_next) ? c_st_hold : c_st_idle;
        else if (data_addr_ok)
          w_next = w_kill ? c_st_cancel : c_st_wait;
      end
      c_st_wait: begin
        if (data_data_ok) w_next = (w_ld_done && stall_next) ? c_st_hold : c_st_idle;
        else if (flush)   w_next = c_st_cancel;
      end
      c_st_hold:   if (flush || !stall_next) w_next = c_st_idle;
      c_st_cancel: if (data_data_ok) w_next = c_st_idle;
      default:     w_next = c_st_idle;
    endcase
  end

  always_comb begin
    data_req   = 1'b0;
    stallreq   = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    case (r_state)
      c_st_idle:   stallreq = w_accept;
      c_st_req: begin
        data_req = 1'b1;
        stallreq = 1'b1;
      end
      c_st_wait:   stallreq = 1'b1;
      c_st_hold:   resp_valid = ~flush;
      c_st_cancel: stallreq = req_valid;
      default:     ;
    endcase
    if (w_ld_done && !stall_next) begin
      resp_valid = 1'b1;
      resp_rdata = data_rdata;
    end else if (resp_valid) begin
      resp_rdata = r_buf;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flushed <= 1'b0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= '0;
      r_wstrb   <= 4'd0;
      r_wdata   <= '0;
      r_buf     <= '0;
    end else begin
      r_flushed <= (r_state == c_st_req) & ~data_addr_ok & w_kill;
      if (w_accept) begin
        r_wr    <= w_is_store;
        r_size  <= w_size;
        r_addr  <= vaddr;
        r_wstrb <= w_wstrb;
        r_wdata <= w_wdata;
      end
      if (w_ld_done && stall_next)
        r_buf <= data_rdata;
      else if (r_state == c_st_hold && w_next == c_st_idle)
        r_buf <= '0;
    end
  end

  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wstrb = r_wstrb;
  assign data_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_req_ctrl.sv
//============================================================================
// tb_dmem_req_ctrl : table vectors, directed sequences and random traffic vs a model
// Rev 1.0
//============================================================================
`default_nettype none

module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn, flush, stall_next, req_valid;
  logic [7:0]  mem_op;
  logic [31:0] vaddr, store_data, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        addr_err_load, addr_err_store, stallreq, data_req, data_wr, resp_valid;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, resp_rdata;

  dmem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall_next(stall_next),
    .req_valid(req_valid), .mem_op(mem_op), .vaddr(vaddr), .store_data(store_data),
    .addr_err_load(addr_err_load), .addr_err_store(addr_err_store), .stallreq(stallreq),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model: which phase the single outstanding access is in
  logic        m_req, m_wait, m_drain, m_kill, m_hold, m_st;
  logic [31:0] m_hold_data, m_addr, m_wdata;
  logic [1:0]  m_size;
  logic [3:0]  m_strb;

  // Observations gathered by cyc() for the directed checks
  int          cnt_stall, cnt_req, cnt_rv;
  logic [1:0]  l_err, l_size;
  logic        l_wr;
  logic [3:0]  l_strb;
  logic [31:0] l_addr, l_wdata, l_rdata;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [1:0]  err;   // {load, store}
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wd;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [107:0] pack_act();
    return {addr_err_load, addr_err_store, stallreq, data_req, resp_valid, resp_rdata,
            data_wr, data_size, data_addr, data_wstrb, data_wdata};
  endfunction

  function automatic void fmt(input logic [7:0] op, input logic [1:0] a, input logic [31:0] sd,
                              output logic st, output logic [1:0] sz, output logic [3:0] strb,
                              output logic [31:0] wd, output logic eld, output logic est);
    st = 1'b0; sz = 2'd0; strb = 4'd0; wd = 32'h0; eld = 1'b0; est = 1'b0;
    case (op)
      8'h80: begin st = 1'b1; strb = 4'(1 << a); wd = {24'd0, sd[7:0]} * 32'h0101_0101; end
      8'h40: begin st = 1'b1; sz = 2'd1; est = a[0]; strb = a[1] ? 4'hC : 4'h3;
                   wd = {16'd0, sd[15:0]} * 32'h0001_0001; end
      8'h20: begin st = 1'b1; sz = 2'd2; est = (a != 2'd0); strb = 4'hF; wd = sd; end
      8'h04, 8'h02: begin sz = 2'd1; eld = a[0]; end
      8'h01: begin sz = 2'd2; eld = (a != 2'd0); end
      default: ;
    endcase
  endfunction

  task automatic model_clear();
    m_req = 0; m_wait = 0; m_drain = 0; m_kill = 0; m_hold = 0; m_st = 0;
    m_hold_data = 0; m_addr = 0; m_wdata = 0; m_size = 0; m_strb = 0;
  endtask

  task automatic clr_cnt();
    cnt_stall = 0; cnt_req = 0; cnt_rv = 0;
    l_err = 0; l_size = 0; l_wr = 0; l_strb = 0; l_addr = 0; l_wdata = 0; l_rdata = 0;
  endtask

  task automatic idle_in();
    req_valid = 0; flush = 0; stall_next = 0; data_addr_ok = 0; data_data_ok = 0;
    mem_op = 0; vaddr = 0; store_data = 0; data_rdata = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic cyc(input string name);
    logic [107:0] e, a;
    logic st, eld, est, idle, acc, done, ld_done, rv;
    logic [1:0] sz; logic [3:0] sb; logic [31:0] wd, rd;
    @(negedge clk);
    fmt(mem_op, vaddr[1:0], store_data, st, sz, sb, wd, eld, est);
    eld = eld & req_valid;
    est = est & req_valid;
    idle    = !(m_req || m_wait || m_drain || m_hold);
    acc     = idle && req_valid && !flush && !eld && !est && (mem_op != 8'h0);
    done    = (m_req && data_addr_ok && data_data_ok && !(m_kill || flush))
           || (m_wait && data_data_ok && !flush);
    ld_done = done && !m_st;
    rv      = (ld_done && !stall_next) || (m_hold && !flush);
    rd      = (m_hold && !flush) ? m_hold_data : (rv ? data_rdata : 32'h0);
    e = {eld, est, m_req || m_wait || acc || (m_drain && req_valid), m_req, rv, rd,
         m_st, m_size, m_addr, m_strb, m_wdata};
    a = pack_act();
    if (!m_req) begin e[70:0] = '0; a[70:0] = '0; end
    else if (!m_st) begin e[31:0] = '0; a[31:0] = '0; end
    check(name, a, e);
    cnt_stall += int'(stallreq); cnt_req += int'(data_req); cnt_rv += int'(resp_valid);
    l_err = {addr_err_load, addr_err_store};
    if (data_req) begin
      l_wr = data_wr; l_size = data_size; l_addr = data_addr; l_strb = data_wstrb; l_wdata = data_wdata;
    end
    if (resp_valid) l_rdata = resp_rdata;
    @(posedge clk);
    if (!resetn) model_clear();
    else if (m_req) begin
      if (data_addr_ok) begin
        m_req = 0;
        if (data_data_ok) begin
          if (ld_done && stall_next) begin m_hold = 1; m_hold_data = data_rdata; end
        end else if (m_kill || flush) m_drain = 1;
        else m_wait = 1;
      end else m_kill = m_kill || flush;
    end else if (m_wait) begin
      if (data_data_ok) begin
        m_wait = 0;
        if (ld_done && stall_next) begin m_hold = 1; m_hold_data = data_rdata; end
      end else if (flush) begin m_wait = 0; m_drain = 1; end
    end else if (m_drain) begin
      if (data_data_ok) m_drain = 0;
    end else if (m_hold) begin
      if (flush || !stall_next) m_hold = 0;
    end else if (acc) begin
      m_req = 1; m_kill = 0; m_st = st; m_size = sz; m_addr = vaddr;
      m_strb = st ? sb : 4'd0; m_wdata = wd;
    end
    #1;
  endtask

  initial begin
    tbl[0]  = '{8'h80, 32'h0000_0103, 32'h0000_00AB, 2'b00, 2'd0, 4'b1000, 32'hABAB_ABAB};
    tbl[1]  = '{8'h80, 32'h0000_0100, 32'h1234_5678, 2'b00, 2'd0, 4'b0001, 32'h7878_7878};
    tbl[2]  = '{8'h80, 32'h0000_0101, 32'h0000_00C3, 2'b00, 2'd0, 4'b0010, 32'hC3C3_C3C3};
    tbl[3]  = '{8'h40, 32'h0000_0102, 32'hCAFE_1234, 2'b00, 2'd1, 4'b1100, 32'h1234_1234};
    tbl[4]  = '{8'h40, 32'h0000_0100, 32'hCAFE_1234, 2'b00, 2'd1, 4'b0011, 32'h1234_1234};
    tbl[5]  = '{8'h40, 32'h0000_0101, 32'hCAFE_1234, 2'b01, 2'd0, 4'b0000, 32'h0};
    tbl[6]  = '{8'h20, 32'h0000_0104, 32'h1122_3344, 2'b00, 2'd2, 4'b1111, 32'h1122_3344};
    tbl[7]  = '{8'h20, 32'h0000_0106, 32'h1122_3344, 2'b01, 2'd0, 4'b0000, 32'h0};
    tbl[8]  = '{8'h01, 32'h0000_0200, 32'h0,         2'b00, 2'd2, 4'b0000, 32'h0};
    tbl[9]  = '{8'h01, 32'h0000_0201, 32'h0,         2'b10, 2'd0, 4'b0000, 32'h0};
    tbl[10] = '{8'h04, 32'h0000_0203, 32'h0,         2'b10, 2'd0, 4'b0000, 32'h0};
    tbl[11] = '{8'h02, 32'h0000_0202, 32'h0,         2'b00, 2'd1, 4'b0000, 32'h0};
    tbl[12] = '{8'h10, 32'h0000_0203, 32'h0,         2'b00, 2'd0, 4'b0000, 32'h0};
    tbl[13] = '{8'h08, 32'h0000_0201, 32'h0,         2'b00, 2'd0, 4'b0000, 32'h0};
    tbl[14] = '{8'h02, 32'h0000_0201, 32'h0,         2'b10, 2'd0, 4'b0000, 32'h0};

    idle_in(); model_clear(); clr_cnt();
    resetn = 0;
    cyc("reset");
    check("reset_all_zero", pack_act(), '0);
    cyc("reset");
    resetn = 1;

    // Formatting / alignment table
    for (int i = 0; i < 15; i++) begin
      logic is_st;
      clr_cnt();
      req_valid = 1; mem_op = tbl[i].op; vaddr = tbl[i].addr; store_data = tbl[i].sd;
      cyc("tbl_issue");
      check("tbl_addr_err", 108'(l_err), 108'(tbl[i].err));
      idle_in();
      if (tbl[i].err == 2'b00) begin
        data_addr_ok = 1; data_data_ok = 1; data_rdata = $urandom;
        cyc("tbl_req");
        is_st = |tbl[i].op[7:5];
        check("tbl_fmt", {l_wr, l_size, l_strb, is_st ? l_wdata : 32'h0, l_addr},
                         {is_st, tbl[i].size, tbl[i].strb, tbl[i].wd, tbl[i].addr});
        idle_in();
      end
      cyc("tbl_idle");
    end

    // sb at ...03, addr_ok then data_ok one cycle apart
    clr_cnt();
    req_valid = 1; mem_op = 8'h80; vaddr = 32'h0000_2003; store_data = 32'h0000_00AB;
    cyc("t1_accept");
    idle_in(); data_addr_ok = 1;        cyc("t1_req");
    idle_in(); data_data_ok = 1;        cyc("t1_wait");
    idle_in();                          cyc("t1_idle");
    check("t1_stall_cycles", 108'(cnt_stall), 108'(3));
    check("t1_no_resp", 108'(cnt_rv), 108'(0));
    check("t1_fields", {l_size, l_strb, l_wdata}, {2'd0, 4'b1000, 32'hABAB_ABAB});

    // lw with addr_ok delayed two cycles
    clr_cnt();
    req_valid = 1; mem_op = 8'h01; vaddr = 32'h0000_1000;
    cyc("t2_accept");
    idle_in();                          cyc("t2_req0");
                                        cyc("t2_req1");
    data_addr_ok = 1;                   cyc("t2_req2");
    idle_in(); data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; cyc("t2_wait");
    idle_in();                          cyc("t2_idle");
    check("t2_req_cycles", 108'(cnt_req), 108'(3));
    check("t2_resp", {108'(cnt_rv), l_rdata}, {108'(1), 32'hDEAD_BEEF});

    // lh whose response lands during a 4-cycle downstream stall
    clr_cnt();
    req_valid = 1; mem_op = 8'h04; vaddr = 32'h0000_1002;
    cyc("t3_accept");
    idle_in(); data_addr_ok = 1;        cyc("t3_req");
    idle_in(); data_data_ok = 1; stall_next = 1; data_rdata = 32'h8000_1234; cyc("t3_wait");
    idle_in(); stall_next = 1;
    for (int k = 0; k < 3; k++) cyc("t3_hold");
    stall_next = 0;                     cyc("t3_release");
                                        cyc("t3_idle");
    check("t3_resp_cycles", 108'(cnt_rv), 108'(4));
    check("t3_resp_data", 108'(l_rdata), 108'(32'h8000_1234));
    check("t3_stall_cycles", 108'(cnt_stall), 108'(3));

    // misaligned sh
    clr_cnt();
    req_valid = 1; mem_op = 8'h40; vaddr = 32'h0000_1001;
    cyc("t4_err"); cyc("t4_err");
    idle_in(); cyc("t4_idle");
    check("t4_no_bus", {108'(cnt_req), 32'(cnt_stall)}, '0);

    // flush in WAIT, second lw waits for the drain
    clr_cnt();
    req_valid = 1; mem_op = 8'h01; vaddr = 32'h0000_1000;
    cyc("t5_accept");
    idle_in(); data_addr_ok = 1;        cyc("t5_req");
    idle_in(); flush = 1;               cyc("t5_flush");
    idle_in(); req_valid = 1; mem_op = 8'h01; vaddr = 32'h0000_2000;
    cyc("t5_cancel"); cyc("t5_cancel");
    data_data_ok = 1; data_rdata = 32'h1111_1111; cyc("t5_drain");
    data_data_ok = 0;                   cyc("t5_accept2");
    idle_in(); data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h2222_2222; cyc("t5_req2");
    idle_in();                          cyc("t5_idle");
    check("t5_resp", {108'(cnt_rv), l_rdata}, {108'(1), 32'h2222_2222});
    check("t5_req_cycles", {108'(cnt_req), l_addr}, {108'(2), 32'h0000_2000});
    check("t5_stall_cycles", 108'(cnt_stall), 108'(8));

    // async reset in the middle of WAIT
    clr_cnt();
    req_valid = 1; mem_op = 8'h01; vaddr = 32'h0000_3000;
    cyc("t6_accept");
    idle_in(); data_addr_ok = 1;        cyc("t6_req");
    idle_in();
    #2 resetn = 0;
    #1 check("t6_async_zero", pack_act(), '0);
    model_clear();
    cyc("t6_in_reset");
    resetn = 1;                         cyc("t6_idle");
    req_valid = 1; mem_op = 8'h01; vaddr = 32'h0000_3004; cyc("t6_accept2");
    idle_in(); data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h5A5A_A5A5; cyc("t6_req2");
    idle_in();                          cyc("t6_idle2");

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      req_valid    = ($urandom_range(0, 1) == 1);
      mem_op       = 8'h01 << $urandom_range(0, 7);
      vaddr        = $urandom;
      if ($urandom_range(0, 3) != 0) vaddr[1:0] = 2'b00;
      store_data   = $urandom;
      data_rdata   = $urandom;
      flush        = ($urandom_range(0, 9) == 0);
      stall_next   = ($urandom_range(0, 2) == 0);
      data_addr_ok = m_req && ($urandom_range(0, 1) == 1);
      data_data_ok = (m_wait || m_drain || data_addr_ok) && ($urandom_range(0, 1) == 1);
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
